rf_multiport: RTL

// - Parametrised integer register file for the RV32 core; successor to the single-write, two-read file.
// - Adds configurable width, depth and read-port count, and a second write port (ALU writeback + load return).
// - Adds optional write-to-read bypass, an x0-hardwired-zero mode and a per-register busy scoreboard.
// - Sits between decode (read/mark) and writeback (write); the hazard unit consumes rd_busy.

---
 rtl/rf_multiport_if.sv | 34 +++
 rtl/rf_multiport.sv | 82 ++++++++
 2 files changed

// File: rtl/rf_multiport_if.sv
// Register-file access bundle: read ports, two write ports, scoreboard mark and busy outputs.
// The master side is decode/writeback. The slave side is the register file itself.
interface rf_multiport_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr0_en;
  logic [AW-1:0]     wr0_addr;
  logic [DW-1:0]     wr0_data;
  logic              wr1_en;
  logic [AW-1:0]     wr1_addr;
  logic [DW-1:0]     wr1_data;
  logic              mark_en;
  logic [AW-1:0]     mark_addr;
  logic [DEPTH-1:0]  busy_vec;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           mark_en, mark_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           mark_en, mark_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/rf_multiport.sv
// Multi-port integer register file for the RV32 core.
// It has two write ports, optional write-to-read bypass, an optional hardwired x0 and a busy scoreboard.
module rf_multiport #(
  parameter int DW      = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter bit X0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input logic clk,
  input logic rst_n,
  rf_multiport_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam bit FULL_RANGE = (DEPTH == (1 << AW));

  logic [DW-1:0]           mem [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic                    w0_ok, w1_ok, mk_ok;
  logic [NRD-1:0][DW-1:0]  rdat;
  logic [NRD-1:0]          rbsy;

  function automatic logic in_range(input logic [AW-1:0] a);
    return FULL_RANGE || (32'(a) < 32'(DEPTH));
  endfunction

  // An access is effective only if it is in range and does not target a hardwired x0.
  function automatic logic usable(input logic [AW-1:0] a);
    return in_range(a) && !(X0_ZERO && (a == '0));
  endfunction

  assign w0_ok = bus.wr0_en  && usable(bus.wr0_addr);
  assign w1_ok = bus.wr1_en  && usable(bus.wr1_addr);
  assign mk_ok = bus.mark_en && usable(bus.mark_addr);

  // Later non-blocking assignments win: port 1 overrides port 0, and a mark overrides a write-side clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      busy <= '0;
    end else begin
      if (w0_ok) begin
        mem[bus.wr0_addr]  <= bus.wr0_data;
        busy[bus.wr0_addr] <= 1'b0;
      end
      if (w1_ok) begin
        mem[bus.wr1_addr]  <= bus.wr1_data;
        busy[bus.wr1_addr] <= 1'b0;
      end
      if (mk_ok) busy[bus.mark_addr] <= 1'b1;
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra   = '0;
    rdat = '0;
    rbsy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      if (in_range(ra)) begin
        rdat[i] = mem[ra];
        rbsy[i] = busy[ra];
        if (X0_ZERO && (ra == '0)) rdat[i] = '0;
        if (BYPASS) begin
          if (w0_ok && (bus.wr0_addr == ra)) begin
            rdat[i] = bus.wr0_data;
            rbsy[i] = 1'b0;
          end
          if (w1_ok && (bus.wr1_addr == ra)) begin
            rdat[i] = bus.wr1_data;
            rbsy[i] = 1'b0;
          end
        end
      end
    end
  end

  assign bus.rd_data  = rdat;
  assign bus.rd_busy  = rbsy;
  assign bus.busy_vec = busy;
endmodule
